decode_issue_stage: RTL and testbench
=====================================

Name: decode_issue_stage

Overview:
- Decode and operand-fetch stage that sits directly upstream of the 8-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and decodes the 4-bit opcode.
- Reads an 8x8 register file, tracks pending writes with a scoreboard to stall RAW/WAW hazards, and presents registered ALU operands to execute.
- Accepts writebacks from downstream and drops its held instruction on a branch flush.

Parameters:
- DATA_W, 8, operand/register width.
- REG_AW, 3, register address width (8 registers, r0 reads 0).
- INSTR_W, 16, instruction width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  16  instruction word.
- out_valid  out  1  issued instruction held for ALU.
- out_ready  in  1  ALU/execute consumes this cycle.
- out_opcode  out  4  opcode to ALU.
- out_a  out  8  signed operand A.
- out_b  out  8  signed operand B or sign-extended immediate.
- out_dir  out  1  shift direction.
- out_rd  out  3  destination register.
- out_wb_en  out  1  instruction writes out_rd.
- out_br_off  out  6  signed branch offset.
- wb_en  in  1  writeback strobe.
- wb_addr  in  3  writeback register.
- wb_data  in  8  writeback value.
- flush  in  1  branch taken downstream; kill held entry.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n.
- Reset values: out_valid=0, all other out_* = 0, all registers = 0, scoreboard = 0.
- Instruction fields: opcode=[15:12].
- R-type (0000–0110): rd=[11:9], rs1=[8:6], rs2=[5:3], dir=[2] (used by 0110 only); a=R[rs1], b=R[rs2].
- ADDI (1001): rd=[11:9], rs1=[8:6], imm6=[5:0] sign-extended to 8 bits; a=R[rs1], b=sext(imm6).
- BEQ/BNE (1011/1100): rs1=[11:9], rs2=[8:6], off6=[5:0]; a=R[rs1], b=R[rs2], out_br_off=off6, out_wb_en=0, out_rd=0.
- Other opcodes: passed as NOPs with a=b=0, out_wb_en=0.
- Write enable: out_wb_en=1 only for 0000–0110 and 1001 with rd!=0.
- Register file: r0 always reads 0. A write to r0 is ignored.
- Register writes: a writeback with wb_en=1 writes R[wb_addr] at the clock edge.
- Read bypass: if wb_en and wb_addr equals a source index (nonzero) in the same cycle, the source reads wb_data.
- Scoreboard: 8 pending bits, bit 0 always 0.
- Hazard: asserted if any used source or the rd of a writing instruction has its pending bit set, unless wb_en clears that bit this cycle. A same-cycle clear allows issue.
- Scoreboard update order per cycle: clear for wb, then clear for flush, then set for accept.
- in_ready = !flush && !hazard && (!out_valid || out_ready). It is purely combinational and does not depend on in_valid.
- Accept = in_valid && in_ready. On accept:
  - out_* load next edge and out_valid=1.
  - if out_wb_en, set pending[rd].
- Latency: one cycle from accept to out_valid.
- Consume without new accept: out_valid goes to 0 when out_valid && out_ready and no accept occurs.
- Back-to-back: issue at one instruction per cycle when hazards are absent.
- Backpressure: out_valid && !out_ready holds all out_* stable.
- Flush:
  - next edge out_valid=0 and no accept that cycle.
  - if the killed entry had out_wb_en, clear pending[out_rd]; this is safe because WAW stalls guarantee a single writer.
  - flush has priority over out_ready.
  - writebacks arriving in a flush cycle still commit.
- Reset mid-operation: all state returns to reset values next edge, and in-flight writebacks are lost.
- Arithmetic: none in this stage beyond sign extension; the ALU performs all operations.

Decomposition:
- Shared package holds:
  - opcode localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SHIFT, OP_ADDI, OP_BEQ, OP_BNE.
  - field bit positions.
  - DATA_W and REG_AW.
- One natural sub-module: regfile_2r1w. It has 2 async read ports, 1 sync write port, r0 hardwired to zero, and the write-to-read bypass.
- Decode, scoreboard, and the output register stay in decode_issue_stage.

Test Plan:
- Reset, then R1=5 and R2=3 via wb; issue ADD r3,r1,r2 (0x0650) -> next cycle out_valid=1, opcode=0000, a=5, b=3, rd=3, wb_en=1; pending[3]=1.
- ADDI r4,r1,-2 (imm6=0x3E) -> b=0xFE, a=5, out_wb_en=1.
- RAW: issue ADD r3, then SUB r5,r3,r1 -> in_ready=0 until wb_en addr=3 data=8; in that same cycle accept, and a=8 via bypass.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0; out_ready=1 -> next instruction issues the following cycle.
- Flush with a held ADD r6 -> out_valid=0 next edge, pending[6]=0, input not accepted that cycle; a subsequent read of r6 issues without stall.
- Writes to r0 ignored (wb r0=0x55 then BEQ r0,r0 -> a=b=0, wb_en=0); reset asserted mid-stall clears out_valid and the scoreboard.

Source files
------------

// File: rtl/decode_issue_stage_pkg.sv
// Shared definitions for the decode/issue stage: widths, opcodes, instruction
// field positions and the issued-instruction record handed to the ALU.
package decode_issue_stage_pkg;

    localparam int DATA_W   = 8;
    localparam int REG_AW   = 3;
    localparam int INSTR_W  = 16;
    localparam int NUM_REGS = 1 << REG_AW;
    localparam int OPC_W    = 4;
    localparam int IMM_W    = 6;

    localparam logic [OPC_W-1:0] OP_ADD   = 4'h0;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'h1;
    localparam logic [OPC_W-1:0] OP_AND   = 4'h2;
    localparam logic [OPC_W-1:0] OP_OR    = 4'h3;
    localparam logic [OPC_W-1:0] OP_XOR   = 4'h4;
    localparam logic [OPC_W-1:0] OP_SLT   = 4'h5;
    localparam logic [OPC_W-1:0] OP_SHIFT = 4'h6;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'h9;
    localparam logic [OPC_W-1:0] OP_BEQ   = 4'hB;
    localparam logic [OPC_W-1:0] OP_BNE   = 4'hC;

    // Branches reuse the rd/rs1 slots for their two sources.
    localparam int OPC_LSB    = 12;
    localparam int RD_LSB     = 9;
    localparam int RS1_LSB    = 6;
    localparam int RS2_LSB    = 3;
    localparam int DIR_BIT    = 2;
    localparam int IMM_LSB    = 0;
    localparam int BR_RS1_LSB = 9;
    localparam int BR_RS2_LSB = 6;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              dir;
        logic [REG_AW-1:0] rd;
        logic              wb_en;
        logic [IMM_W-1:0]  br_off;
    } issue_t;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/decode_issue_stage_regfile_2r1w.sv
// 8x8 register file: two async read ports with same-cycle write bypass,
// one synchronous write port, r0 hardwired to zero.
module regfile_2r1w
    import decode_issue_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 :
                       (we_i && waddr_i == raddr_a_i) ? wdata_i : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 :
                       (we_i && waddr_i == raddr_b_i) ? wdata_i : mem_q[raddr_b_i];

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/operand-fetch stage ahead of the ALU: decodes, reads operands,
// stalls on scoreboard hazards and holds one issued instruction for execute.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPC_W-1:0]         out_opcode,
    output logic signed [DATA_W-1:0] out_a,
    output logic signed [DATA_W-1:0] out_b,
    output logic                     out_dir,
    output logic [REG_AW-1:0]        out_rd,
    output logic                     out_wb_en,
    output logic signed [IMM_W-1:0]  out_br_off,
    input  logic                     wb_en,
    input  logic [REG_AW-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     flush
);

    logic [OPC_W-1:0]    opc;
    logic                is_rtype, is_addi, is_branch, dec_wb_en;
    logic [REG_AW-1:0]   rs1_idx, rs2_idx, rd_idx;
    logic [DATA_W-1:0]   rf_a, rf_b;
    logic [NUM_REGS-1:0] pend_q, pend_d, pend_live, wb_clr;
    logic                hazard, accept;
    logic                valid_q, valid_d;
    issue_t              issue_q, issue_d;

    // Unused source slots decode to r0, which never reads as pending.
    always_comb begin
        opc       = in_instr[OPC_LSB +: OPC_W];
        is_rtype  = (opc <= OP_SHIFT);
        is_addi   = (opc == OP_ADDI);
        is_branch = (opc == OP_BEQ) || (opc == OP_BNE);
        rs1_idx   = '0;
        rs2_idx   = '0;
        rd_idx    = '0;
        if (is_rtype) begin
            rs1_idx = in_instr[RS1_LSB +: REG_AW];
            rs2_idx = in_instr[RS2_LSB +: REG_AW];
            rd_idx  = in_instr[RD_LSB +: REG_AW];
        end else if (is_addi) begin
            rs1_idx = in_instr[RS1_LSB +: REG_AW];
            rd_idx  = in_instr[RD_LSB +: REG_AW];
        end else if (is_branch) begin
            rs1_idx = in_instr[BR_RS1_LSB +: REG_AW];
            rs2_idx = in_instr[BR_RS2_LSB +: REG_AW];
        end
        dec_wb_en = (is_rtype || is_addi) && (rd_idx != '0);
    end

    regfile_2r1w u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a_i (rs1_idx),
        .rdata_a_o (rf_a),
        .raddr_b_i (rs2_idx),
        .rdata_b_o (rf_b),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data)
    );

    always_comb begin
        wb_clr = '0;
        if (wb_en) wb_clr[wb_addr] = 1'b1;
        pend_live = pend_q & ~wb_clr;
        hazard    = pend_live[rs1_idx] || pend_live[rs2_idx] ||
                    (dec_wb_en && pend_live[rd_idx]);
        in_ready  = !flush && !hazard && (!valid_q || out_ready);
        accept    = in_valid && in_ready;

        // Ordering matters: writeback clear, then flush clear, then accept set.
        pend_d = pend_live;
        if (flush && valid_q && issue_q.wb_en) pend_d[issue_q.rd] = 1'b0;
        if (accept && dec_wb_en) pend_d[rd_idx] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        issue_d.opcode = opc;
        issue_d.a      = rf_a;
        issue_d.b      = is_addi ? sext_imm(in_instr[IMM_LSB +: IMM_W]) : rf_b;
        issue_d.dir    = (opc == OP_SHIFT) && in_instr[DIR_BIT];
        issue_d.rd     = rd_idx;
        issue_d.wb_en  = dec_wb_en;
        issue_d.br_off = is_branch ? in_instr[IMM_LSB +: IMM_W] : '0;

        if (flush)          valid_d = 1'b0;
        else if (accept)    valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
        else                valid_d = valid_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            issue_q <= '0;
            pend_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pend_q  <= pend_d;
            if (accept) issue_q <= issue_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_opcode = issue_q.opcode;
    assign out_a      = issue_q.a;
    assign out_b      = issue_q.b;
    assign out_dir    = issue_q.dir;
    assign out_rd     = issue_q.rd;
    assign out_wb_en  = issue_q.wb_en;
    assign out_br_off = issue_q.br_off;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the stage.
module tb_decode_issue_stage;

    logic               clk = 1'b0;
    logic               rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [15:0]        in_instr;
    logic [3:0]         out_opcode;
    logic signed [7:0]  out_a, out_b;
    logic               out_dir, out_wb_en;
    logic [2:0]         out_rd;
    logic signed [5:0]  out_br_off;
    logic               wb_en, flush;
    logic [2:0]         wb_addr;
    logic [7:0]         wb_data;

    always #5 clk = ~clk;

    decode_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_dir    (out_dir),
        .out_rd     (out_rd),
        .out_wb_en  (out_wb_en),
        .out_br_off (out_br_off),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [7:0] m_reg [8];
    bit   [7:0] m_pend;
    logic       m_valid, m_dir, m_wben;
    logic [3:0] m_opc;
    logic [7:0] m_a, m_b;
    logic [2:0] m_rd;
    logic [5:0] m_off;

    typedef struct packed {
        logic [3:0] opc;
        logic       u1, u2;
        logic [2:0] s1, s2, rd;
        logic       wr, dir, useimm;
        logic [7:0] imm;
        logic [5:0] off;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] ins);
        dec_t d;
        d = '0;
        d.opc = ins[15:12];
        if (d.opc <= 4'd6) begin
            d.u1 = 1'b1; d.u2 = 1'b1;
            d.s1 = ins[8:6]; d.s2 = ins[5:3]; d.rd = ins[11:9];
            d.wr = (d.rd != 3'd0);
            d.dir = (d.opc == 4'd6) ? ins[2] : 1'b0;
        end else if (d.opc == 4'd9) begin
            d.u1 = 1'b1; d.s1 = ins[8:6]; d.rd = ins[11:9];
            d.wr = (d.rd != 3'd0);
            d.useimm = 1'b1;
            d.imm = {{2{ins[5]}}, ins[5:0]};
        end else if (d.opc == 4'hB || d.opc == 4'hC) begin
            d.u1 = 1'b1; d.u2 = 1'b1;
            d.s1 = ins[11:9]; d.s2 = ins[8:6];
            d.off = ins[5:0];
        end
        return d;
    endfunction

    function automatic logic [7:0] read_reg(input logic [2:0] idx);
        if (idx == 3'd0) return 8'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return m_reg[idx];
    endfunction

    function automatic bit busy(input logic [2:0] idx);
        return (idx != 3'd0) && m_pend[idx] && !(wb_en && wb_addr == idx);
    endfunction

    function automatic logic model_ready();
        dec_t d;
        bit   hz;
        d  = decode(in_instr);
        hz = (d.u1 && busy(d.s1)) || (d.u2 && busy(d.s2)) || (d.wr && busy(d.rd));
        return !flush && !hz && (!m_valid || out_ready);
    endfunction

    function automatic logic [31:0] dut_outs();
        return {out_valid, out_opcode, out_a, out_b, out_dir, out_rd, out_wb_en, out_br_off};
    endfunction

    function automatic logic [31:0] mdl_outs();
        return {m_valid, m_opc, m_a, m_b, m_dir, m_rd, m_wben, m_off};
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        dec_t       d;
        logic       acc, rs, wbe, fl, ordy;
        logic [2:0] wba;
        logic [7:0] wbd, na, nb;
        d    = decode(in_instr);
        acc  = in_valid && model_ready();
        na   = d.u1 ? read_reg(d.s1) : 8'd0;
        nb   = d.useimm ? d.imm : (d.u2 ? read_reg(d.s2) : 8'd0);
        rs   = rst_n; wbe = wb_en; wba = wb_addr; wbd = wb_data;
        fl   = flush; ordy = out_ready;
        @(posedge clk);
        if (!rs) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 8'd0;
            m_pend = '0; m_valid = 0; m_opc = 0; m_a = 0; m_b = 0;
            m_dir = 0; m_rd = 0; m_wben = 0; m_off = 0;
        end else begin
            if (wbe && wba != 3'd0) m_reg[wba] = wbd;
            if (wbe) m_pend[wba] = 1'b0;
            if (fl && m_valid && m_wben) m_pend[m_rd] = 1'b0;
            if (acc && d.wr) m_pend[d.rd] = 1'b1;
            if (fl) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1; m_opc = d.opc; m_a = na; m_b = nb;
                m_dir = d.dir; m_rd = d.rd; m_wben = d.wr; m_off = d.off;
            end else if (ordy) m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_wb(input logic [2:0] a, input logic [7:0] v);
        wb_en = 1'b1; wb_addr = a; wb_data = v;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 16'h0000; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 3'd0; wb_data = 8'd0; flush = 1'b0;
        tick(); tick();
        n_checks++;
        if (dut_outs() !== 32'h0) begin
            n_fail++; $display("FAIL reset_outs: got %h want %h", dut_outs(), 32'h0);
        end
        rst_n = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add_issue();
        do_wb(3'd1, 8'd5);
        do_wb(3'd2, 8'd3);
        in_instr = 16'h0650; in_valid = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL add_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (dut_outs() !== {1'b1, 4'h0, 8'd5, 8'd3, 1'b0, 3'd3, 1'b1, 6'd0}) begin
            n_fail++; $display("FAIL add_issue: got %h want %h", dut_outs(),
                               {1'b1, 4'h0, 8'd5, 8'd3, 1'b0, 3'd3, 1'b1, 6'd0});
        end
        in_instr = 16'h1AC8; #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL add_pending_r3: in_ready got %b want 0", in_ready);
        end
    endtask

    task automatic test_addi_back_to_back();
        in_instr = 16'h987E; in_valid = 1'b1; out_ready = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL addi_ready: got %b want 1", in_ready);
        end
        tick();
        n_checks++;
        if (dut_outs() !== {1'b1, 4'h9, 8'd5, 8'hFE, 1'b0, 3'd4, 1'b1, 6'd0}) begin
            n_fail++; $display("FAIL addi_issue: got %h want %h", dut_outs(),
                               {1'b1, 4'h9, 8'd5, 8'hFE, 1'b0, 3'd4, 1'b1, 6'd0});
        end
    endtask

    task automatic test_raw_bypass();
        in_instr = 16'h1AC8; in_valid = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL raw_stall0: in_ready got %b want 0", in_ready);
        end
        tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++; $display("FAIL raw_stall1: valid/ready got %b want 00", {out_valid, in_ready});
        end
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'd8; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL raw_release: in_ready got %b want 1", in_ready);
        end
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (dut_outs() !== {1'b1, 4'h1, 8'd8, 8'd5, 1'b0, 3'd5, 1'b1, 6'd0}) begin
            n_fail++; $display("FAIL raw_bypass: got %h want %h", dut_outs(),
                               {1'b1, 4'h1, 8'd8, 8'd5, 1'b0, 3'd5, 1'b1, 6'd0});
        end
        do_wb(3'd4, 8'h0A);
        do_wb(3'd5, 8'h0B);
    endtask

    task automatic test_backpressure();
        in_instr = 16'h0E50; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_instr = 16'h3850; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready);
            end
            tick();
            n_checks++;
            if (dut_outs() !== {1'b1, 4'h0, 8'd5, 8'd3, 1'b0, 3'd7, 1'b1, 6'd0}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", i, dut_outs(),
                                   {1'b1, 4'h0, 8'd5, 8'd3, 1'b0, 3'd7, 1'b1, 6'd0});
            end
        end
        out_ready = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: in_ready got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (dut_outs() !== {1'b1, 4'h3, 8'd5, 8'd3, 1'b0, 3'd4, 1'b1, 6'd0}) begin
            n_fail++; $display("FAIL bp_next: got %h want %h", dut_outs(),
                               {1'b1, 4'h3, 8'd5, 8'd3, 1'b0, 3'd4, 1'b1, 6'd0});
        end
        do_wb(3'd7, 8'h07);
        do_wb(3'd4, 8'h04);
    endtask

    task automatic test_flush();
        in_instr = 16'h0C50; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        flush = 1'b1; in_instr = 16'h3850; out_ready = 1'b1;
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h11; #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_ready: got %b want 0", in_ready);
        end
        tick();
        flush = 1'b0; wb_en = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_kill: out_valid got %b want 0", out_valid);
        end
        in_instr = 16'h0F98; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_pend_clear: in_ready got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (dut_outs() !== {1'b1, 4'h0, 8'h00, 8'h11, 1'b0, 3'd7, 1'b1, 6'd0}) begin
            n_fail++; $display("FAIL flush_after: got %h want %h", dut_outs(),
                               {1'b1, 4'h0, 8'h00, 8'h11, 1'b0, 3'd7, 1'b1, 6'd0});
        end
        do_wb(3'd7, 8'h77);
    endtask

    task automatic test_r0();
        do_wb(3'd0, 8'h55);
        in_instr = 16'hB005; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (dut_outs() !== {1'b1, 4'hB, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 6'd5}) begin
            n_fail++; $display("FAIL r0_beq: got %h want %h", dut_outs(),
                               {1'b1, 4'hB, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 6'd5});
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        in_instr = 16'h0650; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_instr = 16'h1AC8; #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_stall: in_ready got %b want 0", in_ready);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; #1;
        n_checks++;
        if ({dut_outs(), in_ready} !== {32'h0, 1'b1}) begin
            n_fail++; $display("FAIL rst_mid_clear: outs %h ready %b want 0 and 1", dut_outs(), in_ready);
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (dut_outs() !== {1'b1, 4'h1, 8'h00, 8'h00, 1'b0, 3'd5, 1'b1, 6'd0}) begin
            n_fail++; $display("FAIL rst_mid_regs: got %h want %h", dut_outs(),
                               {1'b1, 4'h1, 8'h00, 8'h00, 1'b0, 3'd5, 1'b1, 6'd0});
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0] opc;
        for (int r = 1; r < 8; r++) do_wb(r[2:0], 8'($urandom));
        for (int i = 0; i < 400; i++) begin
            opc       = 4'($urandom_range(0, 15));
            in_instr  = {opc, 12'($urandom)};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = ($urandom_range(0, 2) == 0);
            wb_addr   = 3'($urandom);
            wb_data   = 8'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            n_checks++;
            if (in_ready !== model_ready()) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, model_ready());
            end
            tick();
            n_checks++;
            if (dut_outs() !== mdl_outs()) begin
                n_fail++; $display("FAIL rand_outs[%0d]: got %h want %h", i, dut_outs(), mdl_outs());
            end
        end
        in_valid = 1'b0; wb_en = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_issue();
        test_addi_back_to_back();
        test_raw_bypass();
        test_backpressure();
        test_flush();
        test_r0();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
